// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register with load-use hazard detection.
// Inserts a bubble on Flush or a load-use stall. Freezes on Hold. Stalls PC and IF/ID on hazard or Hold.
module id_ex_pipeline_register #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Flush,
  input  logic                  Hold,
  input  logic [REG_ADDR_W-1:0] IF_IDRegisterRs,
  input  logic [REG_ADDR_W-1:0] IF_IDRegisterRt,
  input  logic [REG_ADDR_W-1:0] IF_IDRegisterRd,
  input  logic [DATA_W-1:0]     IDReadData1,
  input  logic [DATA_W-1:0]     IDReadData2,
  input  logic [DATA_W-1:0]     IDImm,
  input  logic                  IDRegWrite,
  input  logic                  IDMemRead,
  input  logic                  IDMemWrite,
  input  logic                  IDMemtoReg,
  input  logic                  IDALUSrc,
  input  logic                  IDRegDst,
  input  logic [1:0]            IDALUOp,
  output logic [REG_ADDR_W-1:0] ID_EXRegisterRs,
  output logic [REG_ADDR_W-1:0] ID_EXRegisterRt,
  output logic [REG_ADDR_W-1:0] ID_EXRegisterRd,
  output logic [DATA_W-1:0]     ID_EXReadData1,
  output logic [DATA_W-1:0]     ID_EXReadData2,
  output logic [DATA_W-1:0]     ID_EXImm,
  output logic                  ID_EXRegWrite,
  output logic                  ID_EXMemRead,
  output logic                  ID_EXMemWrite,
  output logic                  ID_EXMemtoReg,
  output logic                  ID_EXALUSrc,
  output logic                  ID_EXRegDst,
  output logic [1:0]            ID_EXALUOp,
  output logic                  PCWrite,
  output logic                  IF_IDWrite,
  output logic                  LoadUseStall
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     imm;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic                  reg_dst;
    logic [1:0]            alu_op;
  } idex_t;

  idex_t stage_q, stage_d, id_in;

  assign id_in = '{
    rs:         IF_IDRegisterRs,
    rt:         IF_IDRegisterRt,
    rd:         IF_IDRegisterRd,
    rd1:        IDReadData1,
    rd2:        IDReadData2,
    imm:        IDImm,
    reg_write:  IDRegWrite,
    mem_read:   IDMemRead,
    mem_write:  IDMemWrite,
    mem_to_reg: IDMemtoReg,
    alu_src:    IDALUSrc,
    reg_dst:    IDRegDst,
    alu_op:     IDALUOp
  };

  // A load in EX whose destination is a source of the ID instruction.
  // Register 0 is never a real dependency.
  assign LoadUseStall = stage_q.mem_read && (stage_q.rt != '0) &&
                        ((stage_q.rt == IF_IDRegisterRs) || (stage_q.rt == IF_IDRegisterRt));

  assign PCWrite    = !(LoadUseStall || Hold);
  assign IF_IDWrite = !(LoadUseStall || Hold);

  always_comb begin
    stage_d = id_in;
    if (Flush)             stage_d = '0;
    else if (Hold)         stage_d = stage_q;
    else if (LoadUseStall) stage_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign ID_EXRegisterRs = stage_q.rs;
  assign ID_EXRegisterRt = stage_q.rt;
  assign ID_EXRegisterRd = stage_q.rd;
  assign ID_EXReadData1  = stage_q.rd1;
  assign ID_EXReadData2  = stage_q.rd2;
  assign ID_EXImm        = stage_q.imm;
  assign ID_EXRegWrite   = stage_q.reg_write;
  assign ID_EXMemRead    = stage_q.mem_read;
  assign ID_EXMemWrite   = stage_q.mem_write;
  assign ID_EXMemtoReg   = stage_q.mem_to_reg;
  assign ID_EXALUSrc     = stage_q.alu_src;
  assign ID_EXRegDst     = stage_q.reg_dst;
  assign ID_EXALUOp      = stage_q.alu_op;

endmodule
